// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor: keeps one reservation per master, drops failing
// exclusive stores before they reach the slave and answers them locally with HEXOKAY=0.
module ahbl_excl_monitor #(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int N_MASTERS    = 2,
    parameter int GRANULE_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int W_TAG = W_ADDR - GRANULE_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_LOCAL} state_t;

    state_t               state;
    logic                 write_p1, excl_p1, fail_p1;
    logic [7:0]           mid_p1;
    logic [W_TAG-1:0]     tag_p1;

    logic [N_MASTERS-1:0] slot_vld, slot_vld_nxt;
    logic [W_TAG-1:0]     slot_tag     [N_MASTERS];
    logic [W_TAG-1:0]     slot_tag_nxt [N_MASTERS];

    logic [W_TAG-1:0]     tag_p0;
    logic                 accept_p0, id_ok_p0, own_hit_p0, fail_p0, fail_wr_p0;
    logic                 pass_done;

    assign tag_p0    = src_haddr[W_ADDR-1:GRANULE_LOG2];
    assign accept_p0 = src_hready && src_htrans[1];
    assign pass_done = (state == ST_PASS) && dst_hready_resp;

    // Next table state from the data phase finishing this cycle (sets and clears)
    always_comb begin
        slot_vld_nxt = slot_vld;
        slot_tag_nxt = slot_tag;
        if (pass_done) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (write_p1 && !dst_hresp && slot_tag[i] == tag_p1)
                    slot_vld_nxt[i] = 1'b0;
                if (mid_p1 == 8'(i) && excl_p1) begin
                    if (write_p1) begin
                        slot_vld_nxt[i] = 1'b0;
                    end else if (!dst_hresp) begin
                        slot_vld_nxt[i] = 1'b1;
                        slot_tag_nxt[i] = tag_p1;
                    end
                end
            end
        end else if (state == ST_LOCAL) begin
            for (int i = 0; i < N_MASTERS; i++)
                if (mid_p1 == 8'(i))
                    slot_vld_nxt[i] = 1'b0;
        end
    end

    // Address phase: reservation lookup against the bypassed table
    always_comb begin
        id_ok_p0   = 1'b0;
        own_hit_p0 = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (src_hmaster == 8'(i)) begin
                id_ok_p0   = 1'b1;
                own_hit_p0 = slot_vld_nxt[i] && (slot_tag_nxt[i] == tag_p0);
            end
        end
    end

    assign fail_wr_p0 = src_hexcl && src_hwrite && !own_hit_p0;
    assign fail_p0    = src_hexcl && (src_hwrite ? !own_hit_p0 : !id_ok_p0);

    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = fail_wr_p0 ? 2'b00 : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hready    = src_hready;
    assign dst_hwdata    = src_hwdata;
    assign src_hrdata    = dst_hrdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            slot_vld <= '0;
        end else begin
            slot_vld <= slot_vld_nxt;
            if (src_hready) begin
                if (!src_htrans[1])
                    state <= ST_IDLE;
                else if (fail_wr_p0)
                    state <= ST_LOCAL;
                else
                    state <= ST_PASS;
            end
        end
    end

    // Data phase registers
    always_ff @(posedge clk) begin
        slot_tag <= slot_tag_nxt;
        if (accept_p0) begin
            write_p1 <= src_hwrite;
            excl_p1  <= src_hexcl;
            mid_p1   <= src_hmaster;
            tag_p1   <= tag_p0;
            fail_p1  <= fail_p0;
        end
    end

    assign src_hready_resp = (state == ST_PASS) ? dst_hready_resp : 1'b1;
    assign src_hresp       = (state == ST_PASS) ? dst_hresp : 1'b0;
    assign src_hexokay     = pass_done && excl_p1 && !fail_p1 && !dst_hresp;

endmodule
